// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch bus between the fetch controller and instruction memory.
// master: fetch controller (drives request/address).
// slave:  instruction memory (drives grant and response).
interface pc_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC sequencer and single-outstanding instruction fetch controller.
// Owns the PC, issues one fetch at a time, holds the fetched instruction until
// decode accepts it, and applies trap > branch > sequential redirects. A fetch
// that is in flight when a redirect arrives is squashed through the kill flag.
// Optional build macro: PC_MISALIGN_TRAP_EN
//   defined   - a branch to a non word-aligned target traps to TRAP_VECTOR
//               and pulses misalign_err.
//   undefined - target bits [1:0] are cleared and misalign_err is tied low.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pc_fetch_ctrl_if.master         imem,
  input  logic                    stall,
  input  logic                    br_taken,
  input  logic [31:0]             br_target,
  input  logic                    trap,
  output logic                    inst_valid,
  output logic [31:0]             inst,
  output logic [31:0]             inst_pc,
  output logic                    misalign_err
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        misalign_q, misalign_d;

  // Redirect decode: whether a redirect applies this cycle and where it goes.
  logic        redirect;
  logic [31:0] redir_pc;

`ifdef PC_MISALIGN_TRAP_EN
  logic br_misaligned;
`else
  logic unused_br_target_lsbs;
  assign unused_br_target_lsbs = ^br_target[1:0];
`endif

  // Redirect selection with trap taking priority over branch; ignored in boot.
  always_comb begin
    redirect   = (state_q != S_BOOT) && (trap || br_taken);
    redir_pc   = {br_target[31:2], 2'b00};
    misalign_d = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    br_misaligned = br_taken && (br_target[1:0] != 2'b00);
    if (trap || br_misaligned) begin
      redir_pc = TRAP_VECTOR;
    end
    misalign_d = (state_q != S_BOOT) && br_misaligned;
`else
    if (trap) begin
      redir_pc = TRAP_VECTOR;
    end
`endif
  end

  // Next-state logic for the fetch FSM, PC, kill flag and decode holding register.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;

    case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        if (redirect) begin
          pc_d = redir_pc;
          // A grant in the redirect cycle was for the old PC: squash its response.
          if (imem.imem_gnt) begin
            kill_d  = 1'b1;
            state_d = S_WAIT;
          end
        end else if (imem.imem_gnt) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect) begin
          pc_d = redir_pc;
          if (imem.imem_rvalid) begin
            // Stale response arrives with the redirect: drop it and refetch now.
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem.imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d       = imem.imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            state_d      = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d         = redir_pc;
          inst_valid_d = 1'b0;
          state_d      = S_REQ;
        end else if (!stall) begin
          pc_d         = pc_q + 32'd4;
          inst_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_VECTOR;
      kill_q       <= 1'b0;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
      inst_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      misalign_q   <= misalign_d;
    end
  end

  assign imem.imem_req  = (state_q == S_REQ);
  assign imem.imem_addr = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed testbench for pc_fetch_ctrl. Inputs change and outputs are sampled
// on the falling clock edge; a simple memory answers each granted request one
// cycle later with data = address ^ 32'hDEAD_0000.
module tb_pc_fetch_ctrl;

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic        EXP_MIS    = 1'b1;
  localparam logic [31:0] EXP_MIS_PC = 32'h0000_0010;
`else
  localparam logic        EXP_MIS    = 1'b0;
  localparam logic [31:0] EXP_MIS_PC = 32'h0000_0200;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        trap = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        misalign_err;

  int checks = 0;
  int failures = 0;

  bit          auto_resp = 1'b1;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (bus.master),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .trap         (trap),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  // Remember whether a request was granted in the cycle that just ended.
  always @(posedge clk) begin
    pend      <= bus.imem_req && bus.imem_gnt;
    pend_addr <= bus.imem_addr;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Advance to the next falling edge and present the memory response for this cycle.
  task automatic tick();
    @(negedge clk);
    if (auto_resp) begin
      bus.imem_rvalid = pend;
      bus.imem_rdata  = pend ? mem_word(pend_addr) : 32'h0;
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({bus.imem_req, inst_valid, misalign_err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl: got req/valid/mis=%b required 000", {bus.imem_req, inst_valid, misalign_err});
    end
    checks++;
    if ({bus.imem_addr, inst, inst_pc} !== {32'h0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_data: got addr=%h inst=%h inst_pc=%h required all zero", bus.imem_addr, inst, inst_pc);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if (bus.imem_req !== 1'b0) begin
      failures++;
      $display("FAIL boot_no_req: got req=%b required 0", bus.imem_req);
    end
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL first_req: got req=%b addr=%h required req=1 addr=00000000", bus.imem_req, bus.imem_addr);
    end
    $display("reset: released, first request at addr %h", bus.imem_addr);
  endtask

  task automatic test_sequence();
    logic [31:0] p;
    for (int i = 0; i < 2; i++) begin
      p = 32'(i * 4);
      checks++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, p}) begin
        failures++;
        $display("FAIL seq_req: got req=%b addr=%h required req=1 addr=%h", bus.imem_req, bus.imem_addr, p);
      end
      tick();
      checks++;
      if ({bus.imem_req, inst_valid} !== 2'b00) begin
        failures++;
        $display("FAIL seq_wait: got req/valid=%b required 00", {bus.imem_req, inst_valid});
      end
      tick();
      checks++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, p, mem_word(p)}) begin
        failures++;
        $display("FAIL seq_inst: got valid=%b pc=%h inst=%h required 1 %h %h", inst_valid, inst_pc, inst, p, mem_word(p));
      end
      $display("sequence: inst_pc=%h inst=%h", inst_pc, inst);
      stall = 1'b0;
      tick();
    end
  endtask

  task automatic test_stall();
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h8}) begin
      failures++;
      $display("FAIL stall_req8: got req=%b addr=%h required 1 00000008", bus.imem_req, bus.imem_addr);
    end
    tick();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({inst_valid, bus.imem_req, inst_pc, inst} !== {2'b10, 32'h8, mem_word(32'h8)}) begin
        failures++;
        $display("FAIL stall_hold: got valid=%b req=%b pc=%h inst=%h required 1 0 00000008 %h",
                 inst_valid, bus.imem_req, inst_pc, inst, mem_word(32'h8));
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr, inst_valid} !== {1'b1, 32'hC, 1'b0}) begin
      failures++;
      $display("FAIL stall_release: got req=%b addr=%h valid=%b required 1 0000000c 0", bus.imem_req, bus.imem_addr, inst_valid);
    end
    tick();
    tick();
    checks++;
    if ({inst_valid, inst_pc} !== {1'b1, 32'hC}) begin
      failures++;
      $display("FAIL stall_next: got valid=%b pc=%h required 1 0000000c", inst_valid, inst_pc);
    end
    $display("stall: held 0x8 for 3 cycles, next inst_pc=%h", inst_pc);
    tick();
  endtask

  task automatic test_branch_wait();
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h10}) begin
      failures++;
      $display("FAIL brw_req10: got req=%b addr=%h required 1 00000010", bus.imem_req, bus.imem_addr);
    end
    tick();
    br_taken  = 1'b1;
    br_target = 32'h200;
    tick();
    br_taken = 1'b0;
    checks++;
    if ({bus.imem_req, bus.imem_addr, inst_valid} !== {1'b1, 32'h200, 1'b0}) begin
      failures++;
      $display("FAIL brw_redirect: got req=%b addr=%h valid=%b required 1 00000200 0", bus.imem_req, bus.imem_addr, inst_valid);
    end
    tick();
    checks++;
    if ({inst_valid, inst} !== {1'b0, mem_word(32'hC)}) begin
      failures++;
      $display("FAIL brw_squash: got valid=%b inst=%h required 0 %h", inst_valid, inst, mem_word(32'hC));
    end
    tick();
    checks++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h200, mem_word(32'h200)}) begin
      failures++;
      $display("FAIL brw_target: got valid=%b pc=%h inst=%h required 1 00000200 %h", inst_valid, inst_pc, inst, mem_word(32'h200));
    end
    $display("branch_wait: redirected to inst_pc=%h", inst_pc);
    tick();
  endtask

  task automatic test_branch_req();
    // Redirect in the same cycle as the grant: the response for 0x204 must be discarded.
    br_taken  = 1'b1;
    br_target = 32'h400;
    tick();
    br_taken = 1'b0;
    checks++;
    if ({bus.imem_req, inst_valid} !== 2'b00) begin
      failures++;
      $display("FAIL brg_wait: got req/valid=%b required 00", {bus.imem_req, inst_valid});
    end
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr, inst_valid} !== {1'b1, 32'h400, 1'b0}) begin
      failures++;
      $display("FAIL brg_kill: got req=%b addr=%h valid=%b required 1 00000400 0", bus.imem_req, bus.imem_addr, inst_valid);
    end
    tick();
    tick();
    checks++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h400, mem_word(32'h400)}) begin
      failures++;
      $display("FAIL brg_target: got valid=%b pc=%h inst=%h required 1 00000400 %h", inst_valid, inst_pc, inst, mem_word(32'h400));
    end
    $display("branch_grant: killed stale fetch, inst_pc=%h", inst_pc);
    // Redirect while the request waits for a grant.
    tick();
    bus.imem_gnt = 1'b0;
    br_taken     = 1'b1;
    br_target    = 32'h500;
    tick();
    br_taken = 1'b0;
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h500}) begin
      failures++;
      $display("FAIL brq_addr: got req=%b addr=%h required 1 00000500", bus.imem_req, bus.imem_addr);
    end
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h500}) begin
      failures++;
      $display("FAIL brq_hold_addr: got req=%b addr=%h required 1 00000500", bus.imem_req, bus.imem_addr);
    end
    bus.imem_gnt = 1'b1;
    tick();
    tick();
    checks++;
    if ({inst_valid, inst_pc} !== {1'b1, 32'h500}) begin
      failures++;
      $display("FAIL brq_target: got valid=%b pc=%h required 1 00000500", inst_valid, inst_pc);
    end
    $display("branch_req: no-grant redirect, inst_pc=%h", inst_pc);
  endtask

  task automatic test_trap_priority();
    stall     = 1'b1;
    trap      = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h300;
    tick();
    stall    = 1'b0;
    trap     = 1'b0;
    br_taken = 1'b0;
    checks++;
    if ({inst_valid, bus.imem_req, bus.imem_addr} !== {2'b01, 32'h10}) begin
      failures++;
      $display("FAIL trap_prio: got valid=%b req=%b addr=%h required 0 1 00000010", inst_valid, bus.imem_req, bus.imem_addr);
    end
    tick();
    tick();
    trap = 1'b1;
    tick();
    trap = 1'b0;
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h10}) begin
      failures++;
      $display("FAIL trap_over_accept: got req=%b addr=%h required 1 00000010", bus.imem_req, bus.imem_addr);
    end
    tick();
    tick();
    checks++;
    if ({inst_valid, inst_pc} !== {1'b1, 32'h10}) begin
      failures++;
      $display("FAIL trap_inst: got valid=%b pc=%h required 1 00000010", inst_valid, inst_pc);
    end
    $display("trap: priority over branch, inst_pc=%h", inst_pc);
  endtask

  task automatic test_wrap();
    br_taken  = 1'b1;
    br_target = 32'hFFFF_FFFC;
    tick();
    br_taken = 1'b0;
    checks++;
    if (bus.imem_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_top: got addr=%h required fffffffc", bus.imem_addr);
    end
    tick();
    tick();
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL wrap_zero: got req=%b addr=%h required 1 00000000", bus.imem_req, bus.imem_addr);
    end
    tick();
    tick();
    $display("wrap: inst_pc=%h after fffffffc", inst_pc);
  endtask

  task automatic test_misalign();
    br_taken  = 1'b1;
    br_target = 32'h202;
    tick();
    br_taken = 1'b0;
    checks++;
    if ({misalign_err, bus.imem_addr} !== {EXP_MIS, EXP_MIS_PC}) begin
      failures++;
      $display("FAIL misalign: got err=%b addr=%h required %b %h", misalign_err, bus.imem_addr, EXP_MIS, EXP_MIS_PC);
    end
    tick();
    checks++;
    if (misalign_err !== 1'b0) begin
      failures++;
      $display("FAIL misalign_pulse: got err=%b required 0", misalign_err);
    end
    tick();
    checks++;
    if ({inst_valid, inst_pc} !== {1'b1, EXP_MIS_PC}) begin
      failures++;
      $display("FAIL misalign_inst: got valid=%b pc=%h required 1 %h", inst_valid, inst_pc, EXP_MIS_PC);
    end
    $display("misalign: inst_pc=%h", inst_pc);
    tick();
  endtask

  task automatic test_reset_midop();
    auto_resp       = 1'b0;
    bus.imem_rvalid = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.imem_req, inst_valid, misalign_err, bus.imem_addr, inst, inst_pc} !== {3'b000, 32'h0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL midop_reset: got req=%b valid=%b err=%b addr=%h inst=%h pc=%h required all zero",
               bus.imem_req, inst_valid, misalign_err, bus.imem_addr, inst, inst_pc);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_BAD0;
    trap            = 1'b1;
    br_taken        = 1'b1;
    br_target       = 32'h700;
    tick();
    bus.imem_rvalid = 1'b0;
    trap            = 1'b0;
    br_taken        = 1'b0;
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr, inst_valid} !== {1'b1, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL midop_restart: got req=%b addr=%h valid=%b required 1 00000000 0", bus.imem_req, bus.imem_addr, inst_valid);
    end
    auto_resp = 1'b1;
    tick();
    tick();
    checks++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h0, mem_word(32'h0)}) begin
      failures++;
      $display("FAIL midop_inst: got valid=%b pc=%h inst=%h required 1 00000000 %h", inst_valid, inst_pc, inst, mem_word(32'h0));
    end
    $display("reset_midop: restarted, inst_pc=%h inst=%h", inst_pc, inst);
  endtask

  initial begin
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    test_reset();
    test_sequence();
    test_stall();
    test_branch_wait();
    test_branch_req();
    test_trap_priority();
    test_wrap();
    test_misalign();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
